step_count_source: RTL and testbench
====================================

Name: step_count_source

Overview:
- Sequential stimulus source that produces an arithmetic count sequence on a valid/ready stream.
- Sits directly upstream of the counter-increment assertion checker. Each accepted beat equals the previous accepted beat plus STEP, modulo 2^WIDTH.
- Software-free: it is started with a start pulse, emits a programmed number of beats, then signals completion.

Parameters:
- WIDTH, 4, bit width of the count value.
- STEP, 1, increment between consecutive beats; legal range 1..2^WIDTH-1.
- LEN_W, 8, bit width of the beat-count field.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a sequence; sampled only in IDLE.
- start_val  input  WIDTH  first value emitted; latched on an accepted start.
- num_beats  input  LEN_W  number of beats to emit; latched on an accepted start.
- abort  input  1  terminates a running sequence.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- out_data  output  WIDTH  current count value.
- out_last  output  1  marks the final beat of the sequence.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at sequence end, normal or aborted.
- wrapped  output  1  sticky; set if any increment overflowed 2^WIDTH during the current sequence.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. out_valid, out_data, out_last, busy, done and wrapped all =0. Latched start_val/num_beats=0.
- Reset dominates every other input. Reset mid-RUN drops out_valid at that edge; the partial sequence is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 with num_beats!=0: latch both fields, out_data<=start_val, beats_left<=num_beats, wrapped<=0, go to RUN.
  - out_valid asserts the cycle after start is sampled, so latency start->first valid = 1 cycle.
  - start=1 with num_beats==0: go to DONE directly. No beat is emitted, wrapped<=0.
  - start outside IDLE is ignored (not queued).
- RUN:
  - out_valid=1 and busy=1. out_last = (beats_left==1).
  - Stall (out_valid && !out_ready): out_data, out_last and beats_left hold stable.
  - Accept, not last: out_data <= (out_data+STEP) mod 2^WIDTH and beats_left decrements. If the WIDTH+1-bit sum has its carry set, wrapped<=1.
  - Accept on last beat: go to DONE. The final beat does not compute or flag a further increment.
  - abort=1: go to DONE at the next edge and out_valid deasserts. Abort takes priority over a simultaneous accept; that beat counts as delivered but no increment occurs.
- DONE: done=1 for exactly one cycle, busy=0, out_valid=0, then go to IDLE. out_data retains its last value. wrapped holds until the next accepted start.
- A new start can be accepted in the first IDLE cycle after DONE, so the minimum gap between sequences is 2 cycles without valid.
- out_valid never deasserts without an accept, except on abort or reset.
- Width rules: increments are unsigned and truncated to WIDTH bits. beats_left is LEN_W bits; num_beats = 2^LEN_W-1 is legal.

Test Plan:
- Basic run: WIDTH=4, STEP=1, start_val=0, num_beats=10, out_ready=1 constantly. Expect:
  - first valid 1 cycle after start;
  - data 0..9 on 10 consecutive cycles, out_last only on 9;
  - done pulses the cycle after the last beat;
  - wrapped=0.
- Backpressure: out_ready toggling 1,0,0,1,... with start_val=3, num_beats=4. Expect:
  - accepted sequence 3,4,5,6;
  - out_data/out_last stable across every stall cycle;
  - exactly 4 handshakes, then one done pulse.
- Wrap-around: start_val=14, STEP=1, num_beats=4. Expect data 14,15,0,1 with wrapped=1 after the 15->0 accept. Then STEP=5, start_val=0, num_beats=3: expect 0,5,10 with wrapped=0.
- Zero length and ignored start:
  - num_beats=0: expect no out_valid and done 1 cycle after start.
  - start pulsed mid-RUN: no effect on the sequence.
- Abort with simultaneous accept: assert abort together with the handshake on the 3rd beat of a 10-beat run. Expect:
  - out_valid low next cycle;
  - done pulse that cycle;
  - only 3 beats accepted; back to IDLE the following cycle.
- Reset mid-run: assert rst for 1 cycle during beat 5. Expect all outputs 0 at that edge, no done pulse, and a subsequent start restarting cleanly from the new start_val.

Source files
------------

// File: rtl/step_count_source_if.sv
// Valid/ready stream carrying one count value per beat, with a last-beat marker.
interface step_count_source_if #(
  parameter int WIDTH = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/step_count_source.sv
// Emits a programmed-length arithmetic sequence (start_val, +STEP, ...) on a
// valid/ready stream, then pulses done for one cycle.
module step_count_source #(
  parameter int WIDTH = 4,
  parameter int STEP  = 1,
  parameter int LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         start_val,
  input  logic [LEN_W-1:0]         num_beats,
  input  logic                     abort,
  step_count_source_if.master      stream,
  output logic                     busy,
  output logic                     done,
  output logic                     wrapped
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  state_t           state, state_nx;
  logic [WIDTH-1:0] data_q, data_nx;
  logic [LEN_W-1:0] left_q, left_nx;
  logic             wrap_q, wrap_nx;
  logic [WIDTH:0]   sum;

  // The extra top bit is the carry that flags a wrap past 2^WIDTH.
  assign sum = {1'b0, data_q} + STEP_EXT;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    state_nx = state;
    data_nx  = data_q;
    left_nx  = left_q;
    wrap_nx  = wrap_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          wrap_nx = 1'b0;
          if (num_beats != '0) begin
            state_nx = RUN;
            data_nx  = start_val;
            left_nx  = num_beats;
          end else begin
            state_nx = DONE;
          end
        end
      end
      RUN: begin
        // Abort wins over a simultaneous accept: the beat is delivered, no increment.
        if (abort) begin
          state_nx = DONE;
        end else if (stream.out_ready) begin
          if (left_q == LEN_W'(1)) begin
            state_nx = DONE;
          end else begin
            data_nx = sum[WIDTH-1:0];
            left_nx = left_q - LEN_W'(1);
            if (sum[WIDTH]) wrap_nx = 1'b1;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      data_q <= '0;
      left_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      state  <= state_nx;
      data_q <= data_nx;
      left_q <= left_nx;
      wrap_q <= wrap_nx;
    end
  end

  assign stream.out_valid = (state == RUN);
  assign stream.out_data  = data_q;
  assign stream.out_last  = (state == RUN) && (left_q == LEN_W'(1));
  assign busy             = (state == RUN);
  assign done             = (state == DONE);
  assign wrapped          = wrap_q;

endmodule

// File: tb/tb_step_count_source.sv
// Drives two sources (STEP=1 and STEP=5) with shared stimulus and checks both
// every cycle against a sequence-list model, plus directed literal scenarios.
module tb_step_count_source;
  localparam int W    = 4;
  localparam int L    = 8;
  localparam int MODV = 1 << W;
  localparam int LOGN = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] start_val = '0;
  logic [L-1:0] num_beats = '0;

  always #5 clk = ~clk;

  step_count_source_if #(.WIDTH(W)) bus1 ();
  step_count_source_if #(.WIDTH(W)) bus5 ();
  assign bus1.out_ready = ready;
  assign bus5.out_ready = ready;

  logic [1:0] busy, done, wrapped;

  step_count_source #(.WIDTH(W), .STEP(1), .LEN_W(L)) dut1 (
    .clk(clk), .rst(rst), .start(start), .start_val(start_val), .num_beats(num_beats),
    .abort(abort), .stream(bus1), .busy(busy[0]), .done(done[0]), .wrapped(wrapped[0])
  );
  step_count_source #(.WIDTH(W), .STEP(5), .LEN_W(L)) dut5 (
    .clk(clk), .rst(rst), .start(start), .start_val(start_val), .num_beats(num_beats),
    .abort(abort), .stream(bus5), .busy(busy[1]), .done(done[1]), .wrapped(wrapped[1])
  );

  logic [1:0]   d_valid, d_last;
  logic [W-1:0] d_data [2];
  assign d_valid   = {bus5.out_valid, bus1.out_valid};
  assign d_last    = {bus5.out_last, bus1.out_last};
  assign d_data[0] = bus1.out_data;
  assign d_data[1] = bus5.out_data;

  // Model: on start, the whole expected sequence is written out; each accept
  // consumes the head entry. Nonzero remaining count means a beat is offered.
  int           step_of [2] = '{1, 5};
  logic [W-1:0] m_seq [2][256];
  int           m_head [2];
  int           m_cnt [2];
  bit           m_done [2];
  bit           m_wrap [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_head[k] = 0; m_cnt[k] = 0; m_done[k] = 1'b0; m_wrap[k] = 1'b0;
      end else if (m_done[k]) begin
        m_done[k] = 1'b0;
      end else if (m_cnt[k] != 0) begin
        if (abort) begin
          m_cnt[k] = 0; m_done[k] = 1'b1;
        end else if (ready) begin
          if (m_cnt[k] == 1) m_done[k] = 1'b1;
          else if (int'(m_seq[k][m_head[k]]) + step_of[k] >= MODV) m_wrap[k] = 1'b1;
          m_head[k]++;
          m_cnt[k]--;
        end
      end else if (start) begin
        m_wrap[k] = 1'b0;
        m_head[k] = 0;
        m_cnt[k]  = int'(num_beats);
        for (int i = 0; i < int'(num_beats); i++)
          m_seq[k][i] = W'((int'(start_val) + i * step_of[k]) % MODV);
        if (num_beats == '0) m_done[k] = 1'b1;
      end
    end
  end

  int           n_pass = 0;
  int           n_total = 0;
  logic [W-1:0] log_v [2][LOGN];
  bit           log_l [2][LOGN];
  int           log_n [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      string s;
      s = $sformatf("dut_step%0d", step_of[k]);
      check({s, ".valid"},   32'(d_valid[k]), 32'(m_cnt[k] != 0));
      check({s, ".busy"},    32'(busy[k]),    32'(m_cnt[k] != 0));
      check({s, ".done"},    32'(done[k]),    32'(m_done[k]));
      check({s, ".wrapped"}, 32'(wrapped[k]), 32'(m_wrap[k]));
      check({s, ".last"},    32'(d_last[k]),  32'(m_cnt[k] == 1));
      if (m_cnt[k] != 0) check({s, ".data"}, 32'(d_data[k]), 32'(m_seq[k][m_head[k]]));
      if (d_valid[k] && ready && log_n[k] < LOGN) begin
        log_v[k][log_n[k]] = d_data[k];
        log_l[k][log_n[k]] = d_last[k];
        log_n[k]++;
      end
    end
  endtask

  // Every cycle passes through here: compare on the falling edge, then let
  // the caller change inputs shortly after.
  task automatic tick();
    @(negedge clk);
    compare();
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (!done[0] && i < budget) begin tick(); i++; end
    check({name, ".done_seen"}, 32'(done[0]), 32'd1);
  endtask

  task automatic check_seq(input string name, input int k, input int base, input int n, input int e[10]);
    check({name, ".count"}, 32'(log_n[k] - base), 32'(n));
    for (int i = 0; i < n && base + i < log_n[k]; i++)
      check($sformatf("%s.beat%0d", name, i), 32'(log_v[k][base + i]), 32'(e[i]));
  endtask

  task automatic go(input logic [W-1:0] sv, input logic [L-1:0] nb);
    start = 1'b1; start_val = sv; num_beats = nb;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int b0, b1, nlast;

    tick(); tick();
    check("reset.valid", 32'(d_valid), 32'd0);
    check("reset.data1", 32'(d_data[0]), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.wrapped", 32'(wrapped), 32'd0);
    rst = 1'b0; ready = 1'b1;
    tick();

    // Basic run 0..9 at full throughput.
    b0 = log_n[0];
    go(4'd0, 8'd10);
    check("basic.first_valid", 32'(d_valid[0]), 32'd1);
    wait_done("basic", 40);
    check_seq("basic", 0, b0, 10, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9});
    nlast = 0;
    for (int i = b0; i < log_n[0]; i++) nlast += int'(log_l[0][i]);
    check("basic.last_count", 32'(nlast), 32'd1);
    check("basic.last_on_9", 32'(log_l[0][b0 + 9]), 32'd1);
    check("basic.wrapped", 32'(wrapped[0]), 32'd0);
    tick();

    // Backpressure: ready pattern 1,0,0 repeating.
    b0 = log_n[0];
    go(4'd3, 8'd4);
    for (int i = 0; i < 64 && !done[0]; i++) begin ready = (i % 3 == 0); tick(); end
    check_seq("backpressure", 0, b0, 4, '{3, 4, 5, 6, 0, 0, 0, 0, 0, 0});
    check("backpressure.done", 32'(done[0]), 32'd1);
    ready = 1'b1;
    tick();

    // Wrap-around with STEP=1.
    b0 = log_n[0];
    go(4'd14, 8'd4);
    wait_done("wrap", 40);
    check_seq("wrap", 0, b0, 4, '{14, 15, 0, 1, 0, 0, 0, 0, 0, 0});
    check("wrap.wrapped", 32'(wrapped[0]), 32'd1);
    tick();

    // STEP=5 from 0: no wrap.
    b1 = log_n[1];
    go(4'd0, 8'd3);
    wait_done("step5", 40);
    check_seq("step5", 1, b1, 3, '{0, 5, 10, 0, 0, 0, 0, 0, 0, 0});
    check("step5.wrapped", 32'(wrapped[1]), 32'd0);
    tick();

    // Zero length: straight to a done pulse, nothing emitted.
    go(4'd5, 8'd0);
    check("zero.done", 32'(done[0]), 32'd1);
    check("zero.valid", 32'(d_valid[0]), 32'd0);
    tick();
    check("zero.done_cleared", 32'(done[0]), 32'd0);

    // Start pulsed mid-run is ignored.
    b0 = log_n[0];
    go(4'd2, 8'd6);
    tick();
    start = 1'b1; start_val = 4'd9; num_beats = 8'd1;
    tick();
    start = 1'b0;
    wait_done("ignored_start", 40);
    check_seq("ignored_start", 0, b0, 6, '{2, 3, 4, 5, 6, 7, 0, 0, 0, 0});
    tick();

    // Abort together with the third handshake.
    b0 = log_n[0];
    go(4'd0, 8'd10);
    tick(); tick();
    check("abort.third_beat", 32'(d_data[0]), 32'd2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort.valid_low", 32'(d_valid[0]), 32'd0);
    check("abort.done", 32'(done[0]), 32'd1);
    check("abort.count", 32'(log_n[0] - b0), 32'd3);
    tick();
    check("abort.idle", 32'(done[0] | busy[0]), 32'd0);

    // Reset during beat 5, then a clean restart.
    go(4'd0, 8'd10);
    repeat (4) tick();
    check("rstmid.beat5", 32'(d_data[0]), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid.valid", 32'(d_valid[0]), 32'd0);
    check("rstmid.data", 32'(d_data[0]), 32'd0);
    check("rstmid.last", 32'(d_last[0]), 32'd0);
    repeat (3) begin
      tick();
      check("rstmid.no_done", 32'(done[0]), 32'd0);
    end
    b0 = log_n[0];
    go(4'd7, 8'd3);
    wait_done("restart", 40);
    check_seq("restart", 0, b0, 3, '{7, 8, 9, 0, 0, 0, 0, 0, 0, 0});
    tick();

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 7) == 0);
      start_val = W'($urandom);
      num_beats = ($urandom_range(0, 24) == 0) ? 8'd255 : L'($urandom_range(0, 12));
      abort     = ($urandom_range(0, 39) == 0);
      ready     = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
